wb_ram_slave: RTL

Wishbone B4 classic slave data memory that responds to the MEM-stage load/store unit. It decodes word reads and byte-lane writes from the master, optionally inserts wait states, and returns exactly one `ack` or `err` per accepted request. It sits on the data bus opposite the pipeline's Wishbone master and is the default data RAM for simulation and FPGA builds.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_ram_array.sv | 31 +++
 rtl/wb_ram_slave.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone data-bus constants and slave FSM state encoding.
package wb_pkg;

  localparam int WB_DW   = 32;  // data width
  localparam int WB_AW   = 32;  // byte-address width
  localparam int WB_SELW = 4;   // byte-lane select width
  localparam int WB_CNTW = 4;   // wait-state counter width (0..15 waits)

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/wb_ram_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Read and write share one address and one enable.
module wb_ram_array
  import wb_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic               clk,
  input  logic               en,
  input  logic [WB_SELW-1:0] we,
  input  logic [IDX_W-1:0]   addr,
  input  logic [WB_DW-1:0]   wdata,
  output logic [WB_DW-1:0]   rdata
);

  logic [WB_DW-1:0] mem [DEPTH];

  // Registered read of the addressed word; selected byte lanes are written.
  // NOTE: the storage has no reset so it maps onto block RAM; state and flags
  // use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < WB_SELW; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic data-RAM slave: one ack or err per accepted request.
// Optional wait states are compiled in with the WB_RAM_WAIT_EN macro; without
// it WAIT_STATES is ignored and every response comes one cycle after accept.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int               DEPTH       = 1024,
  parameter logic [WB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int               WAIT_STATES = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [WB_SELW-1:0] wbs_sel_i,
  input  logic [WB_AW-1:0]   wbs_addr_i,
  input  logic [WB_DW-1:0]   wbs_dat_i,
  output logic [WB_DW-1:0]   wbs_dat_o,
  output logic               wbs_ack_o,
  output logic               wbs_err_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Bus-side decode: offset from base, range check and word index.
  logic             req;
  logic [WB_AW-1:0] offset;
  logic             bus_err;
  logic [IDX_W-1:0] bus_idx;

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign offset  = wbs_addr_i - BASE_ADDR;
  assign bus_err = ((offset >> (IDX_W + 2)) != '0) || (wbs_sel_i == '0);
  assign bus_idx = offset[IDX_W+1:2];

  logic [1:0]         state_q, state_d;
  logic               we_q, err_q;
  logic [IDX_W-1:0]   cur_idx;
  logic [WB_SELW-1:0] cur_sel;
  logic [WB_DW-1:0]   cur_dat;
  logic               cur_we, cur_err;
  logic               ram_en;
  logic [WB_SELW-1:0] ram_we;
  logic [WB_DW-1:0]   ram_rdata;

`ifdef WB_RAM_WAIT_EN
  localparam logic [WB_CNTW-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? '0 : WB_CNTW'(WAIT_STATES - 1);

  logic [WB_CNTW-1:0] cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WB_SELW-1:0] sel_q;
  logic [WB_DW-1:0]   dat_q;
`else
  localparam bit wait_states_unused = (WAIT_STATES != 0);
`endif

  // Next-state logic; a dropped cyc during WAIT aborts the request.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef WB_RAM_WAIT_EN
      ST_IDLE: if (req) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (!wbs_cyc_i)         state_d = ST_IDLE;
        else if (cnt_q == '0)   state_d = ST_RESP;
      end
`else
      ST_IDLE: if (req) state_d = ST_RESP;
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request seen by the RAM on the edge entering RESP: live bus from IDLE,
  // latched copy from WAIT.
  always_comb begin
    cur_idx = bus_idx;
    cur_sel = wbs_sel_i;
    cur_dat = wbs_dat_i;
    cur_we  = wbs_we_i;
    cur_err = bus_err;
`ifdef WB_RAM_WAIT_EN
    if (state_q == ST_WAIT) begin
      cur_idx = idx_q;
      cur_sel = sel_q;
      cur_dat = dat_q;
      cur_we  = we_q;
      cur_err = err_q;
    end
`endif
  end

  // The RAM is accessed exactly once per response; reset blocks the write.
  assign ram_en = (state_d == ST_RESP) && rst_i;
  assign ram_we = (ram_en && cur_we && !cur_err) ? cur_sel : '0;

  wb_ram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (cur_idx),
    .wdata (cur_dat),
    .rdata (ram_rdata)
  );

  // State register, request latch at acceptance and wait countdown.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef WB_RAM_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req) begin
        we_q  <= wbs_we_i;
        err_q <= bus_err;
`ifdef WB_RAM_WAIT_EN
        idx_q <= bus_idx;
        sel_q <= wbs_sel_i;
        dat_q <= wbs_dat_i;
        cnt_q <= WAIT_LOAD;
`endif
      end
`ifdef WB_RAM_WAIT_EN
      if (state_q == ST_WAIT && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
`endif
    end
  end

  // Responses are decoded from the RESP state; read data only on a read ack.
  assign wbs_ack_o = (state_q == ST_RESP) && !err_q;
  assign wbs_err_o = (state_q == ST_RESP) &&  err_q;
  assign wbs_dat_o = (wbs_ack_o && !we_q) ? ram_rdata : '0;

endmodule
